hsi_rx_msg_ctrl: RTL and testbench
==================================

HSI_RX_MSG_CTRL -- requirements
Module: hsi_rx_msg_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, message buffer capacity in bytes (power of two, 4..64).
REQ-002 Parameter GAP_TICKS, default 192, idle clk_en ticks after the last frame that close a message (SHALL exceed one decoder frame period).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 clk_en  in  1  bit-rate tick shared with the decoder.
REQ-006 dc_q  in  8  decoded byte.
REQ-007 dc_q_rdy  in  1  byte valid, parity good.
REQ-008 dc_pb_err  in  1  frame received with parity error.
REQ-009 dc_en  out  1  decoder enable; the integration ANDs it into the decoder's n_rst.
REQ-010 rd_data  out  8  buffered byte at the read pointer.
REQ-011 rd_valid  out  1  rd_data valid.
REQ-012 rd_ready  in  1  consumer accepts rd_data.
REQ-013 msg_len  out  clog2(DEPTH)+1  byte count of the completed message.
REQ-014 msg_done  out  1  one-cycle pulse: good message available.
REQ-015 msg_err  out  1  one-cycle pulse: message discarded.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 err_cnt  out  8  discarded-message count; present only with HSI_RX_ERR_CNT_EN.

Function
REQ-018 FSM states: IDLE, RECV, DRAIN, DISCARD.
REQ-019 dc_q_rdy and dc_pb_err SHALL be sampled only when clk_en=1; each is a single-tick event.
REQ-020 IDLE/RECV, dc_q_rdy with count<DEPTH: write dc_q at wr_ptr, wr_ptr++, count++, gap counter cleared, next state RECV.
REQ-021 IDLE/RECV, dc_q_rdy with count==DEPTH: byte dropped, err flag set, gap counter cleared, state RECV.
REQ-022 IDLE/RECV, dc_pb_err: byte not stored, err flag set, gap counter cleared, state RECV.
REQ-023 RECV: gap counter increments per clk_en tick; when it reaches GAP_TICKS, the message closes.
REQ-024 If dc_q_rdy or dc_pb_err coincides with the gap reaching GAP_TICKS, the frame event SHALL win and the message does not close.
REQ-025 Close with err flag clear: go to DRAIN, pulse msg_done, latch msg_len=count.
REQ-026 Close with err flag set: go to DISCARD, pulse msg_err.
REQ-027 Close with count==0 cannot occur because RECV is only entered on a frame event.
REQ-028 DISCARD lasts exactly one cycle: clear pointers, count and err flag, then go to IDLE.
REQ-029 DRAIN: dc_en=0; rd_valid=1 while rd_ptr<msg_len; rd_data=buf[rd_ptr] combinationally; rd_valid&rd_ready advances rd_ptr.
REQ-030 DRAIN: acceptance of the last byte returns to IDLE the next cycle with pointers and count cleared; rd_valid is 0 in that cycle.
REQ-031 rd_data SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-032 dc_en=1 in IDLE and RECV; 0 in DRAIN and DISCARD; frame events arriving while dc_en=0 are ignored.
REQ-033 msg_len holds its value until the next msg_done.

Reset
REQ-034 rst=1 SHALL give: state IDLE, dc_en=1, rd_valid=0, msg_done=0, msg_err=0, busy=0, msg_len=0, err_cnt=0, all pointers, counters and flags 0.
REQ-035 rst takes effect in any state, including mid-RECV and mid-DRAIN; the partial message is lost and no pulses are emitted; buffer contents need not be cleared.

Configuration
REQ-036 Macro HSI_RX_ERR_CNT_EN defined: err_cnt increments on every msg_err pulse and saturates at 255.
REQ-037 HSI_RX_ERR_CNT_EN undefined: the err_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-038 Package hsi_rx_pkg SHALL hold the FSM state encoding and the DEPTH/GAP_TICKS defaults.
REQ-039 Sub-module hsi_rx_buf SHALL implement the DEPTH x 8 register file: one write port, one combinational read port, no reset on storage.

Verification
REQ-040 Three good bytes 0xA5,0x01,0xFF, then 192 idle ticks -> msg_done pulse, msg_len=3, reads return A5,01,FF, then IDLE.
REQ-041 Two good bytes, one dc_pb_err, then gap -> msg_err pulse, no rd_valid, return to IDLE, err_cnt=1 when the macro is defined.
REQ-042 DEPTH+1 good bytes -> msg_err on close, buffer emptied.
REQ-043 Drain with rd_ready toggling 1-0-1 -> rd_data stable while stalled, no byte lost or duplicated.
REQ-044 dc_q_rdy in the same cycle the gap counter hits GAP_TICKS -> byte stored, message stays in RECV.
REQ-045 rst asserted mid-DRAIN after 1 of 3 bytes read -> next cycle IDLE, rd_valid=0, dc_en=1, msg_len=0.

Source files
------------

// File: rtl/hsi_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hsi_rx_pkg
//  Purpose  : Shared definitions for the HSI receive message controller:
//             FSM state encoding and the default buffer depth / gap length.
//  Revision : 1.0 - initial release
// ============================================================================
package hsi_rx_pkg;

    localparam int DEPTH_DEFAULT     = 16;
    localparam int GAP_TICKS_DEFAULT = 192;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

endpackage : hsi_rx_pkg
`default_nettype wire

// File: rtl/hsi_rx_buf.sv
`default_nettype none
// ============================================================================
//  Module   : hsi_rx_buf
//  Purpose  : DEPTH x 8 message byte store. One synchronous write port and
//             one combinational read port. Storage is never reset.
//  Ports    : clk      - system clock
//             we_i     - write enable
//             waddr_i  - write address
//             wdata_i  - write data
//             raddr_i  - read address
//             rdata_o  - read data (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module hsi_rx_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : hsi_rx_buf
`default_nettype wire

// File: rtl/hsi_rx_msg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hsi_rx_msg_ctrl
//  Purpose  : Collects decoded bytes into a message buffer, closes the
//             message after GAP_TICKS idle bit ticks, then either drains it
//             through a valid/ready read port (good message) or discards it
//             (parity error or overflow). The decoder is held off while a
//             message is drained or discarded.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             clk_en             - bit-rate tick shared with the decoder
//             dc_q/dc_q_rdy      - decoded byte and its valid strobe
//             dc_pb_err          - frame received with parity error
//             dc_en              - decoder enable
//             rd_data/rd_valid/rd_ready - byte read-out handshake
//             msg_len            - length of the last good message
//             msg_done/msg_err   - one-cycle completion / discard pulses
//             busy               - controller not in IDLE
//             err_cnt            - saturating discard count
//  Config   : HSI_RX_ERR_CNT_EN  - when defined, adds err_cnt port/counter
//  Revision : 1.0 - initial release
// ============================================================================
module hsi_rx_msg_ctrl
    import hsi_rx_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int GAP_TICKS = GAP_TICKS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic [7:0]                dc_q,
    input  logic                      dc_q_rdy,
    input  logic                      dc_pb_err,
    output logic                      dc_en,
    output logic [7:0]                rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [$clog2(DEPTH):0]    msg_len,
    output logic                      msg_done,
    output logic                      msg_err,
    output logic                      busy
`ifdef HSI_RX_ERR_CNT_EN
    ,
    output logic [7:0]                err_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP_TICKS + 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   len_q, len_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            merr_q, merr_d;

    logic            w_we;
    logic            w_rx_byte;
    logic            w_rx_perr;
    logic            w_rd_avail;
    logic [CW-1:0]   w_rd_next;

    // Frame strobes are only meaningful on a bit tick.
    assign w_rx_byte  = clk_en & dc_q_rdy;
    assign w_rx_perr  = clk_en & dc_pb_err;
    assign w_rd_avail = (state_q == ST_DRAIN) && (rd_ptr_q < len_q);
    assign w_rd_next  = rd_ptr_q + CW'(1);

    hsi_rx_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (dc_q),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            merr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
            done_q   <= done_d;
            merr_q   <= merr_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        gap_d    = gap_q;
        err_d    = err_q;
        done_d   = 1'b0;
        merr_d   = 1'b0;
        w_we     = 1'b0;

        case (state_q)
            ST_IDLE, ST_RECV: begin
                // A frame event always beats a gap timeout on the same tick.
                if (w_rx_byte || w_rx_perr) begin
                    state_d = ST_RECV;
                    gap_d   = '0;
                    if (w_rx_perr) begin
                        err_d = 1'b1;
                    end else if (count_q == CW'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        w_we     = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = count_q + CW'(1);
                    end
                end else if ((state_q == ST_RECV) && clk_en) begin
                    if (gap_q == GW'(GAP_TICKS - 1)) begin
                        gap_d = '0;
                        if (err_q) begin
                            state_d = ST_DISCARD;
                            merr_d  = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                            done_d  = 1'b1;
                            len_d   = count_q;
                        end
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end

            ST_DRAIN: begin
                if (w_rd_avail && rd_ready) begin
                    rd_ptr_d = w_rd_next;
                    if (w_rd_next == len_q) begin
                        state_d  = ST_IDLE;
                        wr_ptr_d = '0;
                        count_d  = '0;
                        rd_ptr_d = '0;
                        err_d    = 1'b0;
                    end
                end
            end

            ST_DISCARD: begin
                state_d  = ST_IDLE;
                wr_ptr_d = '0;
                count_d  = '0;
                rd_ptr_d = '0;
                err_d    = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        dc_en    = (state_q == ST_IDLE) || (state_q == ST_RECV);
        busy     = (state_q != ST_IDLE);
        rd_valid = w_rd_avail;
    end

    assign msg_len  = len_q;
    assign msg_done = done_q;
    assign msg_err  = merr_q;

`ifdef HSI_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (merr_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule : hsi_rx_msg_ctrl
`default_nettype wire

// File: tb/tb_hsi_rx_msg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hsi_rx_msg_ctrl
//  Purpose  : Self-checking bench for hsi_rx_msg_ctrl. Directed stimulus
//             pushes expected events (DONE/ERR pulses, read bytes) into a
//             queue; a monitor pops and compares as the DUT presents them.
//  Config   : HSI_RX_ERR_CNT_EN - also checks err_cnt when defined
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hsi_rx_msg_ctrl;

    localparam int DEPTH = 16;
    localparam int GAP   = 192;

    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;
    localparam logic [1:0] K_RD   = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic [7:0] dc_q;
    logic       dc_q_rdy;
    logic       dc_pb_err;
    logic       dc_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] msg_len;
    logic       msg_done;
    logic       msg_err;
    logic       busy;
`ifdef HSI_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    hsi_rx_msg_ctrl #(
        .DEPTH     (DEPTH),
        .GAP_TICKS (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .dc_q      (dc_q),
        .dc_q_rdy  (dc_q_rdy),
        .dc_pb_err (dc_pb_err),
        .dc_en     (dc_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .msg_len   (msg_len),
        .msg_done  (msg_done),
        .msg_err   (msg_err),
        .busy      (busy)
`ifdef HSI_RX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    // One bit tick with optional frame event, followed by a quiet cycle.
    task automatic tick(input bit rdy, input bit perr, input logic [7:0] d);
        clk_en    = 1'b1;
        dc_q_rdy  = rdy;
        dc_pb_err = perr;
        dc_q      = d;
        @(posedge clk); #1;
        clk_en    = 1'b0;
        dc_q_rdy  = 1'b0;
        dc_pb_err = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (msg_done) begin
                e = (q.size() != 0) ? q[0] : '0;
                checks++;
                if (e.kind != K_DONE || e.val != {3'b000, msg_len}) begin
                    errors++;
                    $display("FAIL msg_done: actual len %0d, expected kind %0d val %0d", msg_len, e.kind, e.val);
                end
                if (q.size() != 0 && e.kind == K_DONE) void'(q.pop_front());
            end
            if (msg_err) begin
                e = (q.size() != 0) ? q[0] : '0;
                checks++;
                if (e.kind != K_ERR) begin
                    errors++;
                    $display("FAIL msg_err: actual pulse, expected kind %0d", e.kind);
                end
                if (q.size() != 0 && e.kind == K_ERR) void'(q.pop_front());
            end
            if (rd_valid) begin
                e = (q.size() != 0) ? q[0] : '0;
                checks++;
                if (e.kind != K_RD || e.val != rd_data) begin
                    errors++;
                    $display("FAIL rd_data: actual %02h, expected kind %0d val %02h", rd_data, e.kind, e.val);
                end
                if (rd_ready && q.size() != 0 && e.kind == K_RD) void'(q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        clk_en    = 1'b0;
        dc_q      = 8'h00;
        dc_q_rdy  = 1'b0;
        dc_pb_err = 1'b0;
        rd_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dc_en",    int'(dc_en),    1);
        check("rst_busy",     int'(busy),     0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_msg_done", int'(msg_done), 0);
        check("rst_msg_err",  int'(msg_err),  0);
        check("rst_msg_len",  int'(msg_len),  0);
`ifdef HSI_RX_ERR_CNT_EN
        check("rst_err_cnt",  int'(err_cnt),  0);
`endif
        rst = 1'b0;

        // Strobes without a bit tick are ignored.
        dc_q_rdy = 1'b1;
        dc_q     = 8'h99;
        @(posedge clk); #1;
        dc_q_rdy = 1'b0;
        check("gated_busy", int'(busy), 0);

        // Good 3-byte message
        tick(1'b1, 1'b0, 8'hA5);
        tick(1'b1, 1'b0, 8'h01);
        tick(1'b1, 1'b0, 8'hFF);
        idle_ticks(GAP - 1);
        check("gap_recv_busy",  int'(busy),  1);
        check("gap_recv_dc_en", int'(dc_en), 1);
        push(K_DONE, 8'd3);
        push(K_RD, 8'hA5);
        push(K_RD, 8'h01);
        push(K_RD, 8'hFF);
        idle_ticks(1);
        wait_idle("good_msg_idle");
        check("good_msg_len", int'(msg_len), 3);
        check("good_dc_en",   int'(dc_en),   1);

        // Parity error discards the message
        tick(1'b1, 1'b0, 8'hA0);
        tick(1'b1, 1'b0, 8'hA1);
        tick(1'b0, 1'b1, 8'h00);
        push(K_ERR, 8'h00);
        idle_ticks(GAP);
        wait_idle("perr_idle");
        check("perr_len_held", int'(msg_len), 3);
`ifdef HSI_RX_ERR_CNT_EN
        check("perr_err_cnt", int'(err_cnt), 1);
`endif

        // Overflow: DEPTH+1 bytes
        for (int i = 0; i <= DEPTH; i++) tick(1'b1, 1'b0, 8'(i));
        push(K_ERR, 8'h00);
        idle_ticks(GAP);
        wait_idle("ovf_idle");
`ifdef HSI_RX_ERR_CNT_EN
        check("ovf_err_cnt", int'(err_cnt), 2);
`endif
        // Buffer emptied: next message starts from zero
        tick(1'b1, 1'b0, 8'h5A);
        push(K_DONE, 8'd1);
        push(K_RD, 8'h5A);
        idle_ticks(GAP);
        wait_idle("after_ovf_idle");
        check("after_ovf_len", int'(msg_len), 1);

        // Drain with rd_ready toggling
        rd_ready = 1'b0;
        tick(1'b1, 1'b0, 8'h11);
        tick(1'b1, 1'b0, 8'h22);
        tick(1'b1, 1'b0, 8'h33);
        push(K_DONE, 8'd3);
        push(K_RD, 8'h11);
        push(K_RD, 8'h22);
        push(K_RD, 8'h33);
        idle_ticks(GAP);
        check("stall_busy", int'(busy), 1);
        for (int i = 0; i < 6; i++) begin
            rd_ready = (i % 2 == 0);
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        wait_idle("toggle_idle");

        // Frame event coincides with gap expiry
        tick(1'b1, 1'b0, 8'h77);
        idle_ticks(GAP - 1);
        tick(1'b1, 1'b0, 8'h88);
        check("coincide_busy", int'(busy), 1);
        idle_ticks(GAP - 1);
        check("coincide_still_recv", int'(dc_en), 1);
        push(K_DONE, 8'd2);
        push(K_RD, 8'h77);
        push(K_RD, 8'h88);
        idle_ticks(1);
        wait_idle("coincide_idle");

        // Reset mid-drain after 1 of 3 bytes
        rd_ready = 1'b0;
        tick(1'b1, 1'b0, 8'h31);
        tick(1'b1, 1'b0, 8'h32);
        tick(1'b1, 1'b0, 8'h33);
        push(K_DONE, 8'd3);
        push(K_RD, 8'h31);
        idle_ticks(GAP);
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b1;
        rd_ready = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy",     int'(busy),     0);
        check("mid_rst_rd_valid", int'(rd_valid), 0);
        check("mid_rst_dc_en",    int'(dc_en),    1);
        check("mid_rst_msg_len",  int'(msg_len),  0);
        check("mid_rst_msg_done", int'(msg_done), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_after", int'(busy), 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hsi_rx_msg_ctrl
`default_nettype wire
